// File: rtl/vga_pkg.sv
// Shared VGA raster definitions: default 640x480@60 timing, coordinate and colour types.
package vga_pkg;

    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    localparam int COORD_W   = 10;
    localparam int COORD_MAX = 1 << COORD_W;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // True when c lies in the half-open window [lo, lo+len).
    function automatic logic in_span(input coord_t c, input int lo, input int len);
        return (int'(c) >= lo) && (int'(c) < lo + len);
    endfunction

endpackage

// File: rtl/vga_pixel_div.sv
// Divides the system clock down to the pixel rate: pixel enable strobe plus a registered DAC pixel clock.
module vga_pixel_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic pix_ce_o,
    output logic vga_clk_o
);

    localparam int DIV_W = $clog2(CLK_DIV);
    typedef logic [DIV_W-1:0] div_t;
    localparam div_t DIV_LAST = div_t'(CLK_DIV - 1);
    localparam div_t DIV_HALF = div_t'(CLK_DIV / 2);

    div_t div_q, div_d;
    logic vga_clk_q, vga_clk_d;

    // VGA_CLK falls on the cycle pixel data changes, so the DAC samples mid-pixel.
    always_comb begin
        pix_ce_o  = (div_q == DIV_LAST);
        div_d     = pix_ce_o ? '0 : div_q + div_t'(1);
        vga_clk_d = (div_d >= DIV_HALF);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q     <= '0;
            vga_clk_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            vga_clk_q <= vga_clk_d;
        end
    end

    assign vga_clk_o = vga_clk_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel coordinates, frame strobe, and a one-pixel-latency output stage
// that keeps registered colour aligned with HS/VS/BLANK_N at the DAC pins.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] Red_in,
    input  logic [7:0] Green_in,
    input  logic [7:0] Blue_in,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_start,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);

    localparam int     H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int     V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST  = coord_t'(V_TOTAL - 1);

    generate
        if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX || CLK_DIV < 2) begin : g_bad_params
            $error("vga_timing_gen: raster totals must fit 10-bit counters and CLK_DIV must be >= 2");
        end
    endgenerate

    logic   pix_ce;
    logic   h_wrap, v_wrap, visible;
    coord_t h_q, h_d, v_q, v_d;
    logic   frame_q, frame_d;
    logic   hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
    rgb_t   rgb_q, rgb_d;

    vga_pixel_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_div (
        .clk_i     (Clk),
        .rst_ni    (Reset_n),
        .pix_ce_o  (pix_ce),
        .vga_clk_o (VGA_CLK)
    );

    // Sync/blank/colour are derived from the pre-increment coordinate, giving one pixel of latency.
    always_comb begin
        h_wrap    = (h_q == H_LAST);
        v_wrap    = (v_q == V_LAST);
        visible   = in_span(h_q, 0, H_VISIBLE) && in_span(v_q, 0, V_VISIBLE);
        frame_d   = pix_ce && h_wrap && v_wrap;
        h_d       = h_q;
        v_d       = v_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        rgb_d     = rgb_q;
        if (pix_ce) begin
            h_d = h_wrap ? '0 : h_q + coord_t'(1);
            if (h_wrap) begin
                v_d = v_wrap ? '0 : v_q + coord_t'(1);
            end
            hs_d      = !in_span(h_q, H_VISIBLE + H_FP, H_SYNC);
            vs_d      = !in_span(v_q, V_VISIBLE + V_FP, V_SYNC);
            blank_n_d = visible;
            rgb_d     = visible ? {Red_in, Green_in, Blue_in} : '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            h_q       <= '0;
            v_q       <= '0;
            frame_q   <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            rgb_q     <= '0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            frame_q   <= frame_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            rgb_q     <= rgb_d;
        end
    end

    assign DrawX       = h_q;
    assign DrawY       = v_q;
    assign frame_start = frame_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = rgb_q.r;
    assign VGA_G       = rgb_q.g;
    assign VGA_B       = rgb_q.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen: default 640x480 instance and a tiny raster instance,
// both compared every clock against a cycle-count arithmetic model of the raster.
module tb_vga_timing_gen;

    typedef struct {
        int cd;
        int hvis, hfp, hsyn, hbp;
        int vvis, vfp, vsyn, vbp;
    } tim_t;

    logic       clk = 1'b0;
    logic       rst_n [2];
    logic [7:0] red_in, green_in, blue_in;
    logic [9:0] drawx [2], drawy [2];
    logic       fs [2], vclk [2], hs [2], vs [2], blank_n [2], sync_n [2];
    logic [7:0] vr [2], vg [2], vb [2];

    always #5 clk = ~clk;

    vga_timing_gen u_dut_def (
        .Clk(clk), .Reset_n(rst_n[0]),
        .Red_in(red_in), .Green_in(green_in), .Blue_in(blue_in),
        .DrawX(drawx[0]), .DrawY(drawy[0]), .frame_start(fs[0]),
        .VGA_CLK(vclk[0]), .VGA_HS(hs[0]), .VGA_VS(vs[0]),
        .VGA_BLANK_N(blank_n[0]), .VGA_SYNC_N(sync_n[0]),
        .VGA_R(vr[0]), .VGA_G(vg[0]), .VGA_B(vb[0])
    );

    vga_timing_gen #(
        .CLK_DIV(4),
        .H_VISIBLE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_dut_small (
        .Clk(clk), .Reset_n(rst_n[1]),
        .Red_in(red_in), .Green_in(green_in), .Blue_in(blue_in),
        .DrawX(drawx[1]), .DrawY(drawy[1]), .frame_start(fs[1]),
        .VGA_CLK(vclk[1]), .VGA_HS(hs[1]), .VGA_VS(vs[1]),
        .VGA_BLANK_N(blank_n[1]), .VGA_SYNC_N(sync_n[1]),
        .VGA_R(vr[1]), .VGA_G(vg[1]), .VGA_B(vb[1])
    );

    tim_t        tm [2];
    int          n_vec = 0;
    int          n_err = 0;
    int          sel;
    int          mode;
    longint      t;
    logic [23:0] col_rec;

    logic        hs_prev, vs_prev;
    int          hs_run, vs_run;
    bit          seen_fs;
    longint      last_fs_t;
    int          exp_hs_first_x, exp_hs_len, exp_vs_first_yx, exp_vs_len, exp_fs_period;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (dut %0d, t=%0d)", tag, obs, exp, sel, t);
        end
    endtask

    // Expected raster state t clocks after reset release: pixel p = t / CLK_DIV,
    // pins show the attributes of pixel p-1.
    function automatic void model(input tim_t m, input longint tc,
                                  output int x, output int y, output bit efs,
                                  output bit evclk, output bit ehs, output bit evs,
                                  output bit ebl);
        int     ht, vt, ph, px, py;
        longint p;
        ht    = m.hvis + m.hfp + m.hsyn + m.hbp;
        vt    = m.vvis + m.vfp + m.vsyn + m.vbp;
        p     = tc / m.cd;
        ph    = int'(tc % m.cd);
        x     = int'(p % ht);
        y     = int'((p / ht) % vt);
        efs   = (ph == 0) && (p > 0) && (p % (ht * vt) == 0);
        evclk = (ph >= m.cd / 2);
        if (p == 0) begin
            ehs = 1'b1;
            evs = 1'b1;
            ebl = 1'b0;
        end else begin
            px  = int'((p - 1) % ht);
            py  = int'(((p - 1) / ht) % vt);
            ehs = !(px >= m.hvis + m.hfp && px < m.hvis + m.hfp + m.hsyn);
            evs = !(py >= m.vvis + m.vfp && py < m.vvis + m.vfp + m.vsyn);
            ebl = (px < m.hvis) && (py < m.vvis);
        end
    endfunction

    task automatic check_outputs(input string tag, input longint tc, output int x);
        int y;
        bit efs, evclk, ehs, evs, ebl;
        model(tm[sel], tc, x, y, efs, evclk, ehs, evs, ebl);
        check_eq({tag, "_xy"}, {12'h0, drawx[sel], drawy[sel]}, {12'h0, x[9:0], y[9:0]});
        check_eq({tag, "_ctl"}, {26'h0, fs[sel], vclk[sel], hs[sel], vs[sel], blank_n[sel], sync_n[sel]},
                 {26'h0, efs, evclk, ehs, evs, ebl, 1'b0});
        check_eq({tag, "_rgb"}, {8'h0, vr[sel], vg[sel], vb[sel]}, ebl ? {8'h0, col_rec} : 32'h0);
    endtask

    task automatic measure();
        if (hs[sel] == 1'b0 && hs_prev == 1'b1) begin
            check_eq("hs_first_x", {22'h0, drawx[sel]}, exp_hs_first_x);
            hs_run = 0;
        end
        if (hs[sel] == 1'b0) hs_run++;
        if (hs[sel] == 1'b1 && hs_prev == 1'b0) check_eq("hs_len", hs_run, exp_hs_len);
        hs_prev = hs[sel];
        if (vs[sel] == 1'b0 && vs_prev == 1'b1) begin
            check_eq("vs_first_yx", {12'h0, drawy[sel], drawx[sel]}, exp_vs_first_yx);
            vs_run = 0;
        end
        if (vs[sel] == 1'b0) vs_run++;
        if (vs[sel] == 1'b1 && vs_prev == 1'b0) check_eq("vs_len", vs_run, exp_vs_len);
        vs_prev = vs[sel];
        if (fs[sel] == 1'b1) begin
            if (seen_fs) check_eq("fs_period", int'(t - last_fs_t), exp_fs_period);
            seen_fs   = 1'b1;
            last_fs_t = t;
        end
    endtask

    task automatic run(input int n);
        int x;
        for (int i = 0; i < n; i++) begin
            check_outputs("cyc", t, x);
            measure();
            if (mode == 0) begin
                red_in   = 8'($urandom);
                green_in = 8'($urandom);
                blue_in  = 8'($urandom);
            end else begin
                red_in   = x[7:0];
                green_in = 8'h4b;
                blue_in  = 8'hff;
            end
            if (int'(t % tm[sel].cd) == tm[sel].cd - 1) col_rec = {red_in, green_in, blue_in};
            t++;
            @(negedge clk);
        end
    endtask

    task automatic hold_reset_and_release(input int which);
        int x;
        sel = which;
        rst_n[which] = 1'b0;
        #1;
        check_outputs("rst_async", 0, x);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_outputs("rst_hold", 0, x);
        end
        @(negedge clk);
        rst_n[which] = 1'b1;
        t       = 0;
        hs_prev = 1'b1;
        vs_prev = 1'b1;
        hs_run  = 0;
        vs_run  = 0;
        seen_fs = 1'b0;
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tm[0] = '{cd: 2, hvis: 640, hfp: 16, hsyn: 96, hbp: 48, vvis: 480, vfp: 10, vsyn: 2, vbp: 33};
        tm[1] = '{cd: 4, hvis: 8, hfp: 1, hsyn: 2, hbp: 1, vvis: 4, vfp: 1, vsyn: 1, vbp: 1};
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        red_in   = 8'h0;
        green_in = 8'h0;
        blue_in  = 8'h0;
        col_rec  = 24'h0;
        mode     = 0;
        t        = 0;
        repeat (2) @(negedge clk);

        // Default raster: two full lines of random colour, then reset at (300,2).
        exp_hs_first_x  = 657;
        exp_hs_len      = 96 * 2;
        exp_vs_first_yx = (490 << 10) | 1;
        exp_vs_len      = 800 * 2 * 2;
        exp_fs_period   = 840000;
        hold_reset_and_release(0);
        run(2 * 1600 + 300 * 2);

        // Mid-frame reset, then colour follows DrawX.
        hold_reset_and_release(0);
        mode = 1;
        run(2 * 1600 + 200);

        // Tiny raster: 12x7 pixels, CLK_DIV 4, three frames of random colour.
        mode            = 0;
        exp_hs_first_x  = 10;
        exp_hs_len      = 2 * 4;
        exp_vs_first_yx = (5 << 10) | 1;
        exp_vs_len      = 12 * 4;
        exp_fs_period   = 12 * 7 * 4;
        hold_reset_and_release(1);
        run(3 * 336 + 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
